// File: rtl/keypad_bcd_if.sv
// Keypad-side inputs and BCD/strobe outputs of the cook-time entry path.
// The master side drives the keys, the slave side is the encoder.
interface keypad_bcd_if;
  logic [9:0] keypad;
  logic       clear;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] mins;
  logic       key_strobe;
  logic       entry_valid;

  modport master (
    output keypad,
    output clear,
    input  sec_ones,
    input  sec_tens,
    input  mins,
    input  key_strobe,
    input  entry_valid
  );

  modport slave (
    input  keypad,
    input  clear,
    output sec_ones,
    output sec_tens,
    output mins,
    output key_strobe,
    output entry_valid
  );
endinterface

// File: rtl/keypad_bcd_encoder.sv
// Debounced 10-key keypad to three-digit BCD entry, digits shifted in from the right.
// One accepted digit per press; a full release must be seen before the next press counts.
module keypad_bcd_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned CNT_W           = 10
) (
  input  logic         clk,
  input  logic         reset,
  keypad_bcd_if.slave  bus
);

  localparam int unsigned KEY_W = 10;
  localparam int unsigned DIG_W = 4;
  localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_ACCEPT,
    S_RELEASE
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [DIG_W-1:0] r_code;
  logic [DIG_W-1:0] r_ones;
  logic [DIG_W-1:0] r_tens;
  logic [DIG_W-1:0] r_mins;
  logic             r_strobe;
  logic             r_valid;

  state_t           w_state;
  logic [CNT_W-1:0] w_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [DIG_W-1:0] w_code_next;
  logic [DIG_W-1:0] w_ones;
  logic [DIG_W-1:0] w_tens;
  logic [DIG_W-1:0] w_mins;
  logic             w_strobe;
  logic             w_valid;
  logic             w_shift;
  logic             w_onehot;
  logic             w_any_key;
  logic [DIG_W-1:0] w_key_code;

  // Single-key detection and index encoding of the pressed key.
  always_comb begin
    w_key_code = '0;
    for (int i = 0; i < int'(KEY_W); i++) begin
      if (bus.keypad[i]) begin
        w_key_code = DIG_W'(i);
      end
    end
    w_any_key = (bus.keypad != '0);
    w_onehot  = w_any_key && ((bus.keypad & (bus.keypad - KEY_W'(1))) == '0);
  end

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // Next-state and next-output logic; digits shift on the DEBOUNCE->ACCEPT
  // transition so the new digit is visible alongside key_strobe.
  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_code_next = r_code;
    w_ones      = r_ones;
    w_tens      = r_tens;
    w_mins      = r_mins;
    w_strobe    = 1'b0;
    w_valid     = r_valid;
    w_shift     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_onehot) begin
          w_code_next = w_key_code;
          w_cnt       = CNT_W'(1);
          w_state     = S_DEBOUNCE;
        end
      end
      S_DEBOUNCE: begin
        if (w_onehot && (w_key_code == r_code)) begin
          if (r_cnt == DB_MAX) begin
            w_state  = S_ACCEPT;
            w_strobe = 1'b1;
            w_shift  = 1'b1;
          end else begin
            w_cnt = w_cnt_inc;
          end
        end else begin
          w_state = S_IDLE;
          w_cnt   = '0;
        end
      end
      S_ACCEPT: begin
        w_state = S_RELEASE;
        w_cnt   = '0;
      end
      S_RELEASE: begin
        if (w_any_key) begin
          w_cnt = '0;
        end else if (w_cnt_inc == DB_MAX) begin
          w_state = S_IDLE;
          w_cnt   = '0;
        end else begin
          w_cnt = w_cnt_inc;
        end
      end
      default: begin
        w_state = S_IDLE;
        w_cnt   = '0;
      end
    endcase

    if (w_shift) begin
      w_mins  = r_tens;
      w_tens  = r_ones;
      w_ones  = r_code;
      w_valid = 1'b1;
    end

    // Clear beats a coincident shift but leaves the FSM and strobe alone.
    if (bus.clear) begin
      w_mins  = '0;
      w_tens  = '0;
      w_ones  = '0;
      w_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_code   <= '0;
      r_ones   <= '0;
      r_tens   <= '0;
      r_mins   <= '0;
      r_strobe <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_code   <= w_code_next;
      r_ones   <= w_ones;
      r_tens   <= w_tens;
      r_mins   <= w_mins;
      r_strobe <= w_strobe;
      r_valid  <= w_valid;
    end
  end

  assign bus.sec_ones    = r_ones;
  assign bus.sec_tens    = r_tens;
  assign bus.mins        = r_mins;
  assign bus.key_strobe  = r_strobe;
  assign bus.entry_valid = r_valid;

endmodule

// File: tb/tb_keypad_bcd_encoder.sv
// Scoreboard bench for keypad_bcd_encoder: each accepted press pushes the expected
// strobe cycle and digits; a negedge monitor pops and compares on every key_strobe.
module tb_keypad_bcd_encoder;

  localparam int unsigned DB = 4;

  typedef struct {
    int cyc;
    int m;
    int t;
    int o;
    int v;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   mdl_m, mdl_t, mdl_o;
  exp_t sb[$];
  exp_t e;

  keypad_bcd_if kb ();

  keypad_bcd_encoder #(
    .DEBOUNCE_CYCLES(DB),
    .CNT_W          (3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (kb.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every strobe must match the oldest pending expectation.
  always @(negedge clk) begin
    if (kb.key_strobe === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", 1, 0);
      end else begin
        e = sb.pop_front();
        check("strobe_cycle", cyc, e.cyc);
        check("mins", int'(kb.mins), e.m);
        check("sec_tens", int'(kb.sec_tens), e.t);
        check("sec_ones", int'(kb.sec_ones), e.o);
        check("entry_valid", int'(kb.entry_valid), e.v);
      end
    end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
      e = sb.pop_front();
      check("missed_strobe", cyc, e.cyc);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_digits(input string tag, input int m, input int t, input int o, input int v);
    check({tag, "_mins"}, int'(kb.mins), m);
    check({tag, "_tens"}, int'(kb.sec_tens), t);
    check({tag, "_ones"}, int'(kb.sec_ones), o);
    check({tag, "_valid"}, int'(kb.entry_valid), v);
  endtask

  task automatic do_reset();
    check("sb_empty_before_reset", sb.size(), 0);
    reset     = 1'b1;
    kb.keypad = '0;
    kb.clear  = 1'b0;
    step(2);
    reset = 1'b0;
    mdl_m = 0;
    mdl_t = 0;
    mdl_o = 0;
    check_digits("reset", 0, 0, 0, 0);
    check("reset_strobe", int'(kb.key_strobe), 0);
  endtask

  task automatic push_exp(input int v);
    exp_t x;
    x.cyc = cyc + int'(DB) + 1;
    x.m   = mdl_m;
    x.t   = mdl_t;
    x.o   = mdl_o;
    x.v   = v;
    sb.push_back(x);
  endtask

  task automatic press(input int code, input int hold, input int rel, input bit acc);
    logic [9:0] k;
    k       = '0;
    k[code] = 1'b1;
    kb.keypad = k;
    if (acc) begin
      mdl_m = mdl_t;
      mdl_t = mdl_o;
      mdl_o = code;
      push_exp(1);
    end
    step(hold);
    kb.keypad = '0;
    step(rel);
  endtask

  initial begin
    int seq[4];
    logic [9:0] k;
    reset     = 1'b1;
    kb.keypad = '0;
    kb.clear  = 1'b0;
    step(1);
    do_reset();

    // Single clean press of key 1.
    press(1, 6, 6, 1'b1);
    check_digits("key1", 0, 0, 1, 1);

    // Sequence 2,3,0,7 with oldest digit dropping out of mins.
    do_reset();
    seq = '{2, 3, 0, 7};
    foreach (seq[i]) press(seq[i], 6, 6, 1'b1);
    check_digits("seq", 3, 0, 7, 1);

    // Bouncing key 5 never reaches the debounce count.
    do_reset();
    press(8, 6, 6, 1'b1);
    press(5, 2, 1, 1'b0);
    press(5, 2, 6, 1'b0);
    check_digits("bounce", 0, 0, 8, 1);
    press(1, 6, 6, 1'b1);
    check_digits("after_bounce", 0, 8, 1, 1);

    // Two keys together are rejected; a lone key afterwards is accepted.
    do_reset();
    kb.keypad = 10'b0000100100;
    step(10);
    kb.keypad = '0;
    step(6);
    check_digits("multikey", 0, 0, 0, 0);
    press(5, 6, 6, 1'b1);
    check_digits("key5", 0, 0, 5, 1);

    // Long hold does not repeat; key 4 during release debounce is ignored.
    do_reset();
    press(9, 50, 2, 1'b1);
    press(4, 8, 6, 1'b0);
    check_digits("no_repeat", 0, 0, 9, 1);
    press(4, 6, 6, 1'b1);
    check_digits("key4", 0, 9, 4, 1);

    // Clear coincident with the accept of key 6: strobe still fires, digits cleared.
    do_reset();
    press(4, 6, 6, 1'b1);
    press(5, 6, 6, 1'b1);
    k         = '0;
    k[6]      = 1'b1;
    kb.keypad = k;
    mdl_m     = 0;
    mdl_t     = 0;
    mdl_o     = 0;
    push_exp(0);
    step(int'(DB));
    kb.clear = 1'b1;
    step(2);
    kb.clear  = 1'b0;
    kb.keypad = '0;
    step(6);
    check_digits("clear", 0, 0, 0, 0);
    press(7, 6, 6, 1'b1);
    check_digits("after_clear", 0, 0, 7, 1);

    // Reset mid-debounce wipes everything and produces no strobe.
    press(8, 6, 6, 1'b1);
    k         = '0;
    k[3]      = 1'b1;
    kb.keypad = k;
    step(2);
    reset     = 1'b1;
    kb.keypad = '0;
    step(1);
    reset = 1'b0;
    check_digits("mid_reset", 0, 0, 0, 0);
    check("mid_reset_strobe", int'(kb.key_strobe), 0);
    step(10);
    check_digits("post_reset", 0, 0, 0, 0);

    check("sb_empty_end", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_bcd_encoder.md
Name: keypad_bcd_encoder

Overview:
- Front end of the cook-time entry path: converts the 10-key numeric keypad into the three BCD digits (mins, sec_tens, sec_ones) that the timer loads and the 7-segment decoders display.
- Handles debouncing, single-key validation and press/release sequencing.
- Shifts each accepted digit in from the right, microwave style.
- Sits between the keypad pins and the timer load interface.

Parameters:
- DEBOUNCE_CYCLES, 1000: consecutive stable cycles required to accept a press and to accept a release (minimum 1).
- CNT_W, 10: width of the debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- keypad  input  10  key lines, bit k high = digit key k pressed; already synchronised to clk.
- clear  input  1  synchronous clear of entered digits; one-cycle pulse or level.
- sec_ones  output  4  BCD units-of-seconds digit.
- sec_tens  output  4  BCD tens-of-seconds digit.
- mins  output  4  BCD minutes digit.
- key_strobe  output  1  one-cycle pulse in the cycle a new digit is shifted in.
- entry_valid  output  1  high once at least one digit has been accepted since the last reset/clear.

Behaviour:
- Reset: sec_ones=0, sec_tens=0, mins=0, key_strobe=0, entry_valid=0, FSM=IDLE, counter=0, captured code=0.
- Valid key: keypad has exactly one bit set (one-hot). Zero bits or two or more bits are invalid; code = index of the set bit (0..9).
- FSM states:
  - IDLE: if keypad is valid, capture code, counter=1, go to DEBOUNCE; otherwise stay.
  - DEBOUNCE:
    - keypad still valid with the same code: counter++.
    - When counter reaches DEBOUNCE_CYCLES: go to ACCEPT.
    - keypad changes (different code, invalid, or released): return to IDLE, counter=0, no strobe.
  - ACCEPT (exactly 1 cycle): shift mins<=sec_tens, sec_tens<=sec_ones, sec_ones<=code; key_strobe=1; entry_valid=1; go to RELEASE.
  - RELEASE:
    - keypad==0: counter++. Any nonzero value: counter=0.
    - When counter reaches DEBOUNCE_CYCLES: go to IDLE.
    - Holding a key never auto-repeats.
- Latency: a clean press held from cycle t produces key_strobe in cycle t+DEBOUNCE_CYCLES+1. Digit outputs are updated and visible from the same cycle as key_strobe. All outputs are registered.
- Shift: the fourth and later digits push the oldest digit out of mins (discarded).
- No range checking: sec_tens may hold 6..9. Normalisation is the timer's job.
- clear:
  - Sets all digits to 0 and entry_valid=0; does not change FSM state or counter.
  - Clear in the same cycle as ACCEPT: clear wins, no shift; key_strobe still pulses. FSM proceeds to RELEASE, so the press is consumed.
- reset overrides everything, including mid-debounce and mid-release.
- Multiple keys pressed during RELEASE hold the FSM in RELEASE until all keys are released.
- Outputs are only ever values 0..9. Unused encodings cannot be produced.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset, then hold keypad=10'b0000000010 for 6 cycles, then release for 6 cycles -> key_strobe exactly once, 5 cycles after the press starts; sec_ones=1, sec_tens=0, mins=0, entry_valid=1.
- Press sequence 2, 3, 0, 7, each held 6 cycles with 6-cycle releases -> after each strobe the digits (mins,sec_tens,sec_ones) read 0,0,2 / 0,2,3 / 2,3,0 / 3,0,7.
- Key 5 bounces: high 2 cycles, low 1, high 2, then released -> no key_strobe, digits unchanged, FSM back to IDLE.
- keypad=10'b0000100100 (keys 2 and 5) held 10 cycles -> no strobe. Then key 5 alone pressed after release -> digits become 0,0,5.
- Key 9 held 50 cycles -> single key_strobe, no repeat. Key 4 pressed before the release debounce completes -> ignored until 4 idle cycles have elapsed.
- After entering 4,5: assert clear coincident with the ACCEPT cycle of key 6 -> digits 0,0,0, entry_valid=0, key_strobe=1. Assert reset in DEBOUNCE -> all outputs 0, no strobe.
